commit_unit: RTL and testbench

- In-order retirement stage directly downstream of the reorder buffer.
- Each cycle it inspects the ROB head and retires it when ready:
  - ALU/load results are written to the architectural register file.
  - Stores are sent to data memory via a req/ack handshake.
  - Branches are checked for misprediction; a mispredict triggers a pipeline flush and PC redirect.
- It pops the ROB by pulsing rd_en.

---
 rtl/commit_unit_if.sv | 49 ++++
 rtl/commit_unit.sv | 121 ++++++++++++
 tb/tb_commit_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/commit_unit_if.sv
// Bundle of ROB-head, register-file, store and flush signals between the
// commit stage (slave) and its surrounding pipeline (master).
interface commit_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned CNT_W = 32
);
    // ROB head
    logic             head_valid;
    logic             head_ready;
    logic [1:0]       head_itype;
    logic [ROB_W-1:0] head_rob_num;
    logic [4:0]       head_rd;
    logic [XLEN-1:0]  head_value;
    logic [XLEN-1:0]  head_addr;
    logic             head_mispredict;
    logic             rob_rd_en;

    // Register-file write port
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic [ROB_W-1:0] rf_wtag;

    // Store port to data memory
    logic             st_req;
    logic [XLEN-1:0]  st_addr;
    logic [XLEN-1:0]  st_data;
    logic             st_ack;

    // Flush / redirect and bookkeeping
    logic             flush;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output head_valid, head_ready, head_itype, head_rob_num, head_rd,
               head_value, head_addr, head_mispredict, st_ack,
        input  rob_rd_en, rf_we, rf_waddr, rf_wdata, rf_wtag,
               st_req, st_addr, st_data, flush, redirect_pc, retired_cnt
    );

    modport slave (
        input  head_valid, head_ready, head_itype, head_rob_num, head_rd,
               head_value, head_addr, head_mispredict, st_ack,
        output rob_rd_en, rf_we, rf_waddr, rf_wdata, rf_wtag,
               st_req, st_addr, st_data, flush, redirect_pc, retired_cnt
    );
endinterface

// File: rtl/commit_unit.sv
// In-order retirement stage: retires the ROB head into the register file,
// drives stores through a req/ack handshake and raises a flush on mispredict.
module commit_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned CNT_W = 32
) (
    input logic          clk,
    input logic          reset,
    commit_unit_if.slave bus
);
    localparam logic [1:0] ITypeBranch = 2'b00;
    localparam logic [1:0] ITypeStore  = 2'b01;

    typedef enum logic [1:0] {
        StCommit = 2'b00,
        StStWait = 2'b01,
        StFlush  = 2'b10
    } state_e;

    state_e           r_state;
    logic             r_st_req;
    logic [XLEN-1:0]  r_st_addr;
    logic [XLEN-1:0]  r_st_data;
    logic             r_flush;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_retired_cnt;

    logic             w_retire;
    logic             w_rd_en;
    logic             w_rf_we;
    logic [4:0]       w_rf_waddr;
    logic [XLEN-1:0]  w_rf_wdata;
    logic [ROB_W-1:0] w_rf_wtag;

    assign w_retire = bus.head_valid & bus.head_ready;

    // Commit outputs are combinational so a ready ALU head retires the same cycle.
    always_comb begin
        w_rd_en    = 1'b0;
        w_rf_we    = 1'b0;
        w_rf_waddr = '0;
        w_rf_wdata = '0;
        w_rf_wtag  = '0;
        if (!reset) begin
            case (r_state)
                StStWait: w_rd_en = bus.st_ack;
                StFlush:  w_rd_en = 1'b0;
                default: begin
                    if (w_retire) begin
                        if (bus.head_itype[1]) begin
                            w_rd_en    = 1'b1;
                            w_rf_we    = (bus.head_rd != 5'd0);
                            w_rf_waddr = bus.head_rd;
                            w_rf_wdata = bus.head_value;
                            w_rf_wtag  = bus.head_rob_num;
                        end else if (bus.head_itype == ITypeBranch) begin
                            w_rd_en = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StCommit;
            r_st_req      <= 1'b0;
            r_st_addr     <= '0;
            r_st_data     <= '0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (w_rd_en) begin
                r_retired_cnt <= r_retired_cnt + CNT_W'(1);
            end
            case (r_state)
                StStWait: begin
                    if (bus.st_ack) begin
                        r_st_req <= 1'b0;
                        r_state  <= StCommit;
                    end
                end
                StFlush: begin
                    r_flush <= 1'b0;
                    r_state <= StCommit;
                end
                default: begin
                    // Also covers the unused encoding, which recovers into COMMIT.
                    r_state <= StCommit;
                    if (w_retire) begin
                        if (bus.head_itype == ITypeBranch && bus.head_mispredict) begin
                            r_flush       <= 1'b1;
                            r_redirect_pc <= bus.head_addr;
                            r_state       <= StFlush;
                        end else if (bus.head_itype == ITypeStore) begin
                            r_st_req  <= 1'b1;
                            r_st_addr <= bus.head_addr;
                            r_st_data <= bus.head_value;
                            r_state   <= StStWait;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rob_rd_en   = w_rd_en;
    assign bus.rf_we       = w_rf_we;
    assign bus.rf_waddr    = w_rf_waddr;
    assign bus.rf_wdata    = w_rf_wdata;
    assign bus.rf_wtag     = w_rf_wtag;
    assign bus.st_req      = r_st_req;
    assign bus.st_addr     = r_st_addr;
    assign bus.st_data     = r_st_data;
    assign bus.flush       = r_flush;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.retired_cnt = r_retired_cnt;
endmodule

// File: tb/tb_commit_unit.sv
// Directed and randomized bench for commit_unit against a transaction-level
// model of retirement, store handshake and flush behaviour.
module tb_commit_unit;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ROB_W = 4;
    localparam int unsigned CNT_W = 32;

    logic clk;
    logic reset;

    commit_unit_if #(.XLEN(XLEN), .ROB_W(ROB_W), .CNT_W(CNT_W)) bus ();

    commit_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model: outstanding store, pending flush cycle, expected registers.
    bit          m_store_busy;
    bit          m_in_flush;
    bit          m_st_req;
    bit   [31:0] m_st_addr;
    bit   [31:0] m_st_data;
    bit          m_flush;
    bit   [31:0] m_redirect;
    bit   [31:0] m_count;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic model_clear();
        m_store_busy = 0;
        m_in_flush   = 0;
        m_st_req     = 0;
        m_st_addr    = 0;
        m_st_data    = 0;
        m_flush      = 0;
        m_redirect   = 0;
        m_count      = 0;
    endtask

    // One clock cycle: drive inputs, check every output, advance the model.
    task automatic step(input bit rst, input bit v, input bit r, input bit [1:0] t,
                        input bit [3:0] tag, input bit [4:0] rd, input bit [31:0] val,
                        input bit [31:0] addr, input bit mp, input bit ack);
        bit        e_pop;
        bit        e_we;
        bit [4:0]  e_waddr;
        bit [31:0] e_wdata;
        bit [3:0]  e_wtag;
        @(negedge clk);
        reset               = rst;
        bus.head_valid      = v;
        bus.head_ready      = r;
        bus.head_itype      = t;
        bus.head_rob_num    = tag;
        bus.head_rd         = rd;
        bus.head_value      = val;
        bus.head_addr       = addr;
        bus.head_mispredict = mp;
        bus.st_ack          = ack;
        #1;
        e_pop = 0; e_we = 0; e_waddr = 0; e_wdata = 0; e_wtag = 0;
        if (rst || m_in_flush) begin
            e_pop = 0;
        end else if (m_store_busy) begin
            e_pop = ack;
        end else if (v && r) begin
            if (t == 2'b10 || t == 2'b11) begin
                e_pop = 1; e_we = (rd != 0); e_waddr = rd; e_wdata = val; e_wtag = tag;
            end else if (t == 2'b00) begin
                e_pop = 1;
            end
        end
        check_eq("rob_rd_en",   bus.rob_rd_en,   e_pop);
        check_eq("rf_we",       bus.rf_we,       e_we);
        check_eq("rf_waddr",    bus.rf_waddr,    e_waddr);
        check_eq("rf_wdata",    bus.rf_wdata,    e_wdata);
        check_eq("rf_wtag",     bus.rf_wtag,     e_wtag);
        check_eq("st_req",      bus.st_req,      m_st_req);
        check_eq("st_addr",     bus.st_addr,     m_st_addr);
        check_eq("st_data",     bus.st_data,     m_st_data);
        check_eq("flush",       bus.flush,       m_flush);
        check_eq("redirect_pc", bus.redirect_pc, m_redirect);
        check_eq("retired_cnt", bus.retired_cnt, m_count);
        if (rst) begin
            model_clear();
        end else begin
            m_count = m_count + 32'(e_pop);
            if (m_in_flush) begin
                m_in_flush = 0;
                m_flush    = 0;
            end else if (m_store_busy) begin
                if (ack) begin
                    m_store_busy = 0;
                    m_st_req     = 0;
                end
            end else if (v && r) begin
                if (t == 2'b00 && mp) begin
                    m_in_flush = 1;
                    m_flush    = 1;
                    m_redirect = addr;
                end else if (t == 2'b01) begin
                    m_store_busy = 1;
                    m_st_req     = 1;
                    m_st_addr    = addr;
                    m_st_data    = val;
                end
            end
        end
    endtask

    bit        h_v, h_r, h_mp;
    bit [1:0]  h_t;
    bit [3:0]  h_tag;
    bit [4:0]  h_rd;
    bit [31:0] h_val, h_addr;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.head_valid = 0; bus.head_ready = 0; bus.head_itype = 0; bus.head_rob_num = 0;
        bus.head_rd = 0; bus.head_value = 0; bus.head_addr = 0; bus.head_mispredict = 0;
        bus.st_ack = 0;
        model_clear();
        repeat (2) @(posedge clk);

        // Outputs stay quiet under reset even with a ready head.
        step(1, 1, 1, 2'b10, 4'd3, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        // ALU retirement, then three back-to-back and an rd=0 one.
        step(0, 1, 1, 2'b10, 4'd3, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        check_eq("first_alu_cnt_pending", m_count, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b11, 4'(i + 4), 5'(i + 1), 32'(i * 7), 0, 0, 0);
        step(0, 1, 1, 2'b10, 4'd9, 5'd0, 32'h1234, 0, 0, 0);
        // Store with ack delayed three cycles.
        step(0, 1, 1, 2'b01, 4'd2, 5'd0, 32'h55, 32'h100, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 1, 2'b01, 4'd2, 5'd0, 32'h55, 32'h100, 0, 0);
        step(0, 1, 1, 2'b01, 4'd2, 5'd0, 32'h55, 32'h100, 0, 1);
        step(0, 0, 0, 2'b00, 4'd0, 5'd0, 0, 0, 0, 0);
        // Mispredicted branch: flush cycle blocks a ready ALU head.
        step(0, 1, 1, 2'b00, 4'd6, 5'd0, 0, 32'h2000, 1, 0);
        step(0, 1, 1, 2'b10, 4'd7, 5'd8, 32'hA5, 0, 0, 0);
        step(0, 1, 1, 2'b10, 4'd7, 5'd8, 32'hA5, 0, 0, 0);
        // Head valid but not ready for five cycles.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 2'b01, 4'd1, 5'd3, 32'h77, 32'h40, 0, 1);
        step(0, 1, 1, 2'b10, 4'd1, 5'd3, 32'h77, 32'h40, 0, 0);
        // Reset while waiting for a store ack, with ack in the reset cycle.
        step(0, 1, 1, 2'b01, 4'd5, 5'd0, 32'h99, 32'h300, 0, 0);
        step(0, 1, 1, 2'b01, 4'd5, 5'd0, 32'h99, 32'h300, 0, 0);
        step(1, 1, 1, 2'b01, 4'd5, 5'd0, 32'h99, 32'h300, 0, 1);
        step(0, 0, 0, 2'b00, 4'd0, 5'd0, 0, 0, 0, 0);

        // Randomized traffic; head is held while a store is outstanding.
        for (int n = 0; n < 3000; n++) begin
            if (!m_store_busy) begin
                h_v    = ($urandom_range(0, 7) != 0);
                h_r    = ($urandom_range(0, 3) != 0);
                h_t    = 2'($urandom_range(0, 3));
                h_tag  = 4'($urandom);
                h_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                h_val  = $urandom;
                h_addr = $urandom;
                h_mp   = $urandom_range(0, 1) == 1;
            end
            step(($urandom_range(0, 63) == 0), h_v, h_r, h_t, h_tag, h_rd, h_val, h_addr, h_mp,
                 ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
